fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage and the hazard unit. Owns the PC register, a single-outstanding request/ready interface to instruction memory, and the IF/ID pipeline register. Consumes stallF/stallD from the hazard unit and branch redirects from decode. Inserts bubbles whenever memory is slow or a redirect is taken.

## Interface
- PC_WIDTH, 32, PC and address width
- INSTR_WIDTH, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stallF  in  1  hazard unit: freeze PC and fetch acceptance
- stallD  in  1  hazard unit: freeze IF/ID register
- PCSrcD  in  1  branch/jump in decode is taken
- PCBranchD  in  PC_WIDTH  redirect target
- imem_req  out  1  fetch request valid
- imem_addr  out  PC_WIDTH  fetch address (= PCF)
- imem_rdata  in  INSTR_WIDTH  fetched instruction, valid when imem_ready
- imem_ready  in  1  memory completes the current request this cycle
- InstrD  out  INSTR_WIDTH  IF/ID instruction (0 = nop on bubble)
- PCPlus4D  out  PC_WIDTH  IF/ID PC+4
- ValidD  out  1  IF/ID holds a real instruction
- PCF  out  PC_WIDTH  current fetch PC

## Operation
- Internal stall = stallF | stallD; the hazard unit drives them identically, so the block treats them as one signal.
- A response is accepted on a cycle with imem_req & imem_ready. There is at most one outstanding request. imem_addr is stable from request until ready.
- Bubble means ValidD←0, InstrD←0, PCPlus4D←0.
- PC arithmetic is PCF+4 modulo 2^PC_WIDTH; 0xFFFFFFFC wraps to 0.
- States are FETCH, HOLD and DRAIN.
- **FETCH:** imem_req=1.
  - ready & ~stall & ~PCSrcD: IF/ID←{rdata, PCF+4, 1}; PCF←PCF+4.
  - ready & ~stall & PCSrcD: bubble; PCF←PCBranchD; the fetched word is discarded.
  - ready & stall: hold_instr←rdata; go to HOLD; PCF and IF/ID are unchanged.
  - ~ready & ~stall & PCSrcD: pending_pc←PCBranchD; bubble; go to DRAIN.
  - ~ready & ~stall & ~PCSrcD: bubble; stay in FETCH.
  - ~ready & stall: no change.
- **HOLD:** imem_req=0.
  - stall: no change.
  - ~stall & ~PCSrcD: IF/ID←{hold_instr, PCF+4, 1}; PCF←PCF+4; go to FETCH.
  - ~stall & PCSrcD: bubble; PCF←PCBranchD; hold_instr is discarded; go to FETCH.
- **DRAIN:** imem_req=1, imem_addr=old PCF.
  - ready: response discarded; PCF←pending_pc; go to FETCH.
  - ~stall: bubble each cycle.
- PCSrcD is ignored while stall=1, because the stalled branch reasserts it. PCSrcD is also ignored in DRAIN, because D holds a bubble there.

## Timing
- Reset (one or more cycles high):
  - State←FETCH, PCF←RESET_PC, hold_instr←0, pending_pc←0, IF/ID bubble.
  - imem_req is forced 0 while reset=1.
  - First request on the cycle after reset deasserts.
- Reset asserted mid-fetch or in DRAIN abandons the request. A late imem_ready arriving after reset is ignored only if it coincides with reset.
- Latency with a zero-wait memory: fetch at cycle n gives InstrD valid at n+1; throughput is one instruction per cycle.
- Each memory wait cycle inserts exactly one bubble when not stalled.
- A taken redirect costs one bubble when memory is ready, or 1 + remaining wait cycles in DRAIN.
- imem_req drops only in HOLD and reset. Address changes only on the edge following acceptance.

## Structure
- Shared cpu_pkg holds:
  - the fetch state encoding (FETCH/HOLD/DRAIN)
  - the NOP_INSTR constant (0)
  - the PC_INCR constant (4)
- Sub-module if_id_register contains the clocked IF/ID register.
  - Inputs: enable, flush, and the {instr, pcplus4, valid} bundle.
  - flush has priority over enable.
- fetch_stage keeps the FSM, PC, hold register and pending register.

## Test plan
- Reset, RESET_PC=0x0, imem_ready=1 constantly, no stall: PCF steps 0,4,8 after reset drops. InstrD shows words at 0,4 on consecutive cycles with ValidD=1.
- imem_ready low for 2 cycles on the fetch of 0x8: two bubbles (ValidD=0, InstrD=0), imem_addr=0x8 held, then the word at 0x8 with PCPlus4D=0xC.
- stall=1 for 3 cycles coinciding with ready on 0x10: HOLD is entered, imem_req=0, and IF/ID is unchanged. On release, InstrD is the word at 0x10 and PCF=0x14, with no refetch.
- PCSrcD=1, PCBranchD=0x40 with ready=1: one bubble, then imem_addr=0x40 and the word at 0x40 in D.
- PCSrcD=1, PCBranchD=0x80 while waiting 3 cycles for ready: DRAIN is entered, imem_addr stays old, the response is discarded, then imem_addr=0x80. No wrong-path ValidD=1 appears.
- PCF=0xFFFFFFFC with ready=1 gives PCF=0x0 and PCPlus4D=0x0. Reset asserted during DRAIN gives PCF=RESET_PC and ValidD=0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_pkg : pipeline-wide fetch state encoding and instruction constants
// Revision: 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int unsigned NOP_INSTR = 0;
  localparam int unsigned PC_INCR   = 4;

endpackage
`default_nettype wire

// File: rtl/if_id_register.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_id_register : IF/ID pipeline register, flush wins over enable
// Revision: 1.0
// ---------------------------------------------------------------------------
module if_id_register
  import cpu_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   flush_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [PC_WIDTH-1:0]    pcplus4_i,
  input  logic                   valid_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]    pcplus4_o,
  output logic                   valid_o
);

  logic [INSTR_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]    pcplus4_q;
  logic                   valid_q;

  // A bubble clears every field so decode sees a clean nop.
  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      instr_q   <= INSTR_WIDTH'(NOP_INSTR);
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else if (enable_i) begin
      instr_q   <= instr_i;
      pcplus4_q <= pcplus4_i;
      valid_q   <= valid_i;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_stage : PC, single-outstanding imem handshake and IF/ID register
// Revision: 1.0
// ---------------------------------------------------------------------------
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stallF,
  input  logic                   stallD,
  input  logic                   PCSrcD,
  input  logic [PC_WIDTH-1:0]    PCBranchD,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_ready,
  output logic [INSTR_WIDTH-1:0] InstrD,
  output logic [PC_WIDTH-1:0]    PCPlus4D,
  output logic                   ValidD,
  output logic [PC_WIDTH-1:0]    PCF
);

  localparam logic [PC_WIDTH-1:0] C_PC_STEP = PC_WIDTH'(PC_INCR);

  fetch_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;
  logic [PC_WIDTH-1:0]    pending_pc_q, pending_pc_d;

  logic                   stall;
  logic [PC_WIDTH-1:0]    pc_plus4;
  logic                   ifid_en;
  logic                   ifid_flush;
  logic [INSTR_WIDTH-1:0] ifid_instr;

  always_comb begin
    stall        = stallF | stallD;
    pc_plus4     = pc_q + C_PC_STEP;
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    pending_pc_d = pending_pc_q;
    ifid_en      = 1'b0;
    ifid_flush   = 1'b0;
    ifid_instr   = imem_rdata;

    case (state_q)
      FETCH: begin
        if (imem_ready) begin
          if (stall) begin
            // Park the word so the memory is not asked for it again.
            hold_instr_d = imem_rdata;
            state_d      = HOLD;
          end else if (PCSrcD) begin
            ifid_flush = 1'b1;
            pc_d       = PCBranchD;
          end else begin
            ifid_en = 1'b1;
            pc_d    = pc_plus4;
          end
        end else if (!stall) begin
          ifid_flush = 1'b1;
          if (PCSrcD) begin
            pending_pc_d = PCBranchD;
            state_d      = DRAIN;
          end
        end
      end

      HOLD: begin
        if (!stall) begin
          state_d = FETCH;
          if (PCSrcD) begin
            ifid_flush = 1'b1;
            pc_d       = PCBranchD;
          end else begin
            ifid_en    = 1'b1;
            ifid_instr = hold_instr_q;
            pc_d       = pc_plus4;
          end
        end
      end

      DRAIN: begin
        // The old-path request must complete before the redirect is issued.
        ifid_flush = !stall;
        if (imem_ready) begin
          pc_d    = pending_pc_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      pending_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  assign imem_req  = (state_q != HOLD) && !reset;
  assign imem_addr = pc_q;
  assign PCF       = pc_q;

  if_id_register #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_if_id (
    .clk_i     (clk),
    .reset_i   (reset),
    .enable_i  (ifid_en),
    .flush_i   (ifid_flush),
    .instr_i   (ifid_instr),
    .pcplus4_i (pc_plus4),
    .valid_i   (1'b1),
    .instr_o   (InstrD),
    .pcplus4_o (PCPlus4D),
    .valid_o   (ValidD)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_stage : directed vector table plus randomized model comparison
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallF, stallD, PCSrcD;
  logic [31:0] PCBranchD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] InstrD, PCPlus4D, PCF;
  logic        ValidD;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  // Garbage on the bus when not ready catches premature capture.
  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stallF     (stallF),
    .stallD     (stallD),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .InstrD     (InstrD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .PCF        (PCF)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst, stl, src;
    logic [31:0] tgt;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr, e_pcf;
    bit          e_val;
    logic [31:0] e_p4;
  } vec_t;

  function automatic vec_t v(bit rst, bit stl, bit src, logic [31:0] tgt, bit rdy,
                             bit req, logic [31:0] addr, logic [31:0] pcf, bit val,
                             logic [31:0] p4);
    vec_t r;
    r.rst = rst; r.stl = stl; r.src = src; r.tgt = tgt; r.rdy = rdy;
    r.e_req = req; r.e_addr = addr; r.e_pcf = pcf; r.e_val = val; r.e_p4 = p4;
    return r;
  endfunction

  vec_t tbl[$];

  // Reference model state: what the fetch stage should hold at any moment.
  logic [31:0] m_pc, m_hold, m_pend, m_instr, m_p4;
  bit          m_holding, m_drain, m_val;

  task automatic model_step(bit r, bit st, bit src, logic [31:0] tgt, bit rdy);
    logic [31:0] rd;
    rd = mem_word(m_pc);
    if (r) begin
      m_pc = 32'h0; m_hold = 0; m_pend = 0; m_holding = 0; m_drain = 0;
      m_val = 0; m_instr = 0; m_p4 = 0;
    end else if (m_holding) begin
      if (!st) begin
        m_holding = 0;
        if (src) begin
          m_val = 0; m_instr = 0; m_p4 = 0; m_pc = tgt;
        end else begin
          m_val = 1; m_instr = m_hold; m_p4 = m_pc + 4; m_pc = m_pc + 4;
        end
      end
    end else if (m_drain) begin
      if (!st) begin m_val = 0; m_instr = 0; m_p4 = 0; end
      if (rdy) begin m_pc = m_pend; m_drain = 0; end
    end else if (rdy) begin
      if (st) begin
        m_hold = rd; m_holding = 1;
      end else if (src) begin
        m_val = 0; m_instr = 0; m_p4 = 0; m_pc = tgt;
      end else begin
        m_val = 1; m_instr = rd; m_p4 = m_pc + 4; m_pc = m_pc + 4;
      end
    end else if (!st) begin
      m_val = 0; m_instr = 0; m_p4 = 0;
      if (src) begin m_pend = tgt; m_drain = 1; end
    end
  endtask

  initial begin
    reset = 1; stallF = 0; stallD = 0; PCSrcD = 0; PCBranchD = 0; imem_ready = 1;

    tbl.push_back(v(1,0,0,32'h0,1,          0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(v(1,0,0,32'h0,1,          0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(v(0,0,0,32'h0,1,          1,32'h0,        32'h4,        1,32'h4));
    tbl.push_back(v(0,0,0,32'h0,1,          1,32'h4,        32'h8,        1,32'h8));
    tbl.push_back(v(0,0,0,32'h0,0,          1,32'h8,        32'h8,        0,32'h0));
    tbl.push_back(v(0,0,0,32'h0,0,          1,32'h8,        32'h8,        0,32'h0));
    tbl.push_back(v(0,0,0,32'h0,1,          1,32'h8,        32'hC,        1,32'hC));
    tbl.push_back(v(0,0,0,32'h0,1,          1,32'hC,        32'h10,       1,32'h10));
    tbl.push_back(v(0,1,0,32'h0,1,          1,32'h10,       32'h10,       1,32'h10));
    tbl.push_back(v(0,1,0,32'h0,0,          0,32'h0,        32'h10,       1,32'h10));
    tbl.push_back(v(0,1,1,32'h40,1,         0,32'h0,        32'h10,       1,32'h10));
    tbl.push_back(v(0,0,0,32'h0,0,          0,32'h0,        32'h14,       1,32'h14));
    tbl.push_back(v(0,0,1,32'h40,1,         1,32'h14,       32'h40,       0,32'h0));
    tbl.push_back(v(0,0,0,32'h0,1,          1,32'h40,       32'h44,       1,32'h44));
    tbl.push_back(v(0,0,1,32'h80,0,         1,32'h44,       32'h44,       0,32'h0));
    tbl.push_back(v(0,0,1,32'hC0,0,         1,32'h44,       32'h44,       0,32'h0));
    tbl.push_back(v(0,0,0,32'h0,1,          1,32'h44,       32'h80,       0,32'h0));
    tbl.push_back(v(0,0,0,32'h0,1,          1,32'h80,       32'h84,       1,32'h84));
    tbl.push_back(v(0,0,1,32'hFFFF_FFFC,1,  1,32'h84,       32'hFFFF_FFFC,0,32'h0));
    tbl.push_back(v(0,0,0,32'h0,1,          1,32'hFFFF_FFFC,32'h0,        1,32'h0));
    tbl.push_back(v(0,1,0,32'h0,1,          1,32'h0,        32'h0,        1,32'h0));
    tbl.push_back(v(0,0,1,32'h100,0,        0,32'h0,        32'h100,      0,32'h0));
    tbl.push_back(v(0,0,1,32'h200,0,        1,32'h100,      32'h100,      0,32'h0));
    tbl.push_back(v(1,0,0,32'h0,1,          0,32'h0,        32'h0,        0,32'h0));
    tbl.push_back(v(0,0,0,32'h0,1,          1,32'h0,        32'h4,        1,32'h4));
    tbl.push_back(v(0,1,0,32'h0,0,          1,32'h4,        32'h4,        1,32'h4));
    tbl.push_back(v(0,0,0,32'h0,1,          1,32'h4,        32'h8,        1,32'h8));

    foreach (tbl[i]) begin
      reset      = tbl[i].rst;
      stallF     = tbl[i].stl;
      stallD     = tbl[i].stl && (i % 2 == 0);
      PCSrcD     = tbl[i].src;
      PCBranchD  = tbl[i].tgt;
      imem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl[%0d] imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req)
        chk($sformatf("tbl[%0d] imem_addr", i), imem_addr, tbl[i].e_addr);
      @(posedge clk);
      #1;
      chk($sformatf("tbl[%0d] PCF", i), PCF, tbl[i].e_pcf);
      chk($sformatf("tbl[%0d] ValidD", i), {31'b0, ValidD}, {31'b0, tbl[i].e_val});
      chk($sformatf("tbl[%0d] PCPlus4D", i), PCPlus4D, tbl[i].e_p4);
      chk($sformatf("tbl[%0d] InstrD", i), InstrD,
          tbl[i].e_val ? mem_word(tbl[i].e_p4 - 32'd4) : 32'h0);
    end

    for (int c = 0; c < 1500; c++) begin
      bit r, sf, sd, src, rdy;
      logic [31:0] tgt;
      r   = (c == 0) || ($urandom_range(63) == 0);
      sf  = ($urandom_range(7) == 0);
      sd  = ($urandom_range(7) == 0);
      src = ($urandom_range(4) == 0);
      rdy = ($urandom_range(9) < 6);
      tgt = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      reset = r; stallF = sf; stallD = sd; PCSrcD = src; PCBranchD = tgt; imem_ready = rdy;
      #1;
      chk($sformatf("rnd[%0d] imem_req", c), {31'b0, imem_req}, {31'b0, !r && !m_holding});
      if (!r && !m_holding)
        chk($sformatf("rnd[%0d] imem_addr", c), imem_addr, m_pc);
      @(posedge clk);
      model_step(r, sf | sd, src, tgt, rdy);
      #1;
      chk($sformatf("rnd[%0d] PCF", c), PCF, m_pc);
      chk($sformatf("rnd[%0d] ValidD", c), {31'b0, ValidD}, {31'b0, m_val});
      chk($sformatf("rnd[%0d] PCPlus4D", c), PCPlus4D, m_p4);
      chk($sformatf("rnd[%0d] InstrD", c), InstrD, m_instr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
